peripheral_ahb4_initiator: RTL



---
 rtl/peripheral_ahb4_initiator.sv | 100 ++++++++++
 1 files changed

// File: rtl/peripheral_ahb4_initiator.sv
// AHB4 (AHB-Lite) single-transfer initiator: valid/ready command stream in,
// one response per command out, with address/data phase overlap.
module peripheral_ahb4_initiator #(
   parameter int         XLEN      = 64,
   parameter int         PLEN      = 64,
   parameter logic [3:0] HPROT_VAL = 4'b0011
) (
   input  logic            HCLK,
   input  logic            HRESET,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [PLEN-1:0] cmd_addr,
   input  logic            cmd_write,
   input  logic [2:0]      cmd_size,
   input  logic [XLEN-1:0] cmd_wdata,
   output logic            rsp_valid,
   output logic [XLEN-1:0] rsp_rdata,
   output logic            rsp_error,
   output logic            HSEL,
   output logic [PLEN-1:0] HADDR,
   output logic [XLEN-1:0] HWDATA,
   input  logic [XLEN-1:0] HRDATA,
   output logic            HWRITE,
   output logic [2:0]      HSIZE,
   output logic [2:0]      HBURST,
   output logic [3:0]      HPROT,
   output logic [1:0]      HTRANS,
   output logic            HMASTLOCK,
   input  logic            HREADY,
   input  logic            HRESP
);

   typedef struct packed {
      logic            valid;
      logic            write;
      logic [2:0]      size;
      logic [PLEN-1:0] addr;
      logic [XLEN-1:0] wdata;
   } xfer_t;

   xfer_t           r_a;
   xfer_t           r_d;
   xfer_t           w_cmd;
   logic            r_cancel;
   logic            r_rsp_valid;
   logic [XLEN-1:0] r_rsp_rdata;
   logic            r_rsp_error;
   logic            w_err1;
   logic            w_adv;
   logic            w_done;
   logic            w_cmd_ready;

   assign w_cmd = '{valid: 1'b1, write: cmd_write, size: cmd_size,
                    addr: cmd_addr, wdata: cmd_wdata};

   // First ERROR cycle: the slave is still stalling but has flagged the error.
   assign w_err1      = r_d.valid && HRESP && !HREADY;
   assign w_adv       = r_a.valid && !r_cancel && HREADY;
   assign w_done      = r_d.valid && HREADY;
   assign w_cmd_ready = !HRESET && (!r_a.valid || (HREADY && !r_cancel && !w_err1));

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_a         <= '0;
         r_d         <= '0;
         r_cancel    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_error <= 1'b0;
      end else begin
         if (w_cmd_ready)
            r_a <= cmd_valid ? w_cmd : '0;
         // A cancelled address phase stays in A and is reissued next cycle.
         if (HREADY)
            r_d <= w_adv ? r_a : '0;
         if (w_err1)
            r_cancel <= 1'b1;
         else if (HREADY)
            r_cancel <= 1'b0;
         r_rsp_valid <= w_done;
         r_rsp_rdata <= (w_done && !r_d.write) ? HRDATA : '0;
         r_rsp_error <= w_done && HRESP;
      end
   end

   assign cmd_ready = w_cmd_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_error = r_rsp_error;
   assign HSEL      = r_a.valid;
   assign HTRANS    = (r_a.valid && !r_cancel) ? 2'b10 : 2'b00;
   assign HADDR     = r_a.addr;
   assign HWRITE    = r_a.write;
   assign HSIZE     = r_a.size;
   assign HWDATA    = r_d.wdata;
   assign HBURST    = 3'b000;
   assign HPROT     = HPROT_VAL;
   assign HMASTLOCK = 1'b0;

endmodule
